// File: rtl/benes_cfg_if.sv
// Stage-word stream from the routing controller into the Benes config loader.
// Optional cfg_parity signal exists only when BENES_CFG_PARITY_EN is defined.
interface benes_cfg_if #(
  parameter int SW_PER_STAGE = 16
) ();
  logic                    cfg_valid;
  logic                    cfg_ready;
  logic [SW_PER_STAGE-1:0] cfg_data;
  logic                    cfg_last;
`ifdef BENES_CFG_PARITY_EN
  logic                    cfg_parity;
`endif

  modport master (
`ifdef BENES_CFG_PARITY_EN
    output cfg_parity,
`endif
    output cfg_valid, cfg_data, cfg_last,
    input  cfg_ready
  );

  modport slave (
`ifdef BENES_CFG_PARITY_EN
    input  cfg_parity,
`endif
    input  cfg_valid, cfg_data, cfg_last,
    output cfg_ready
  );
endinterface

// File: rtl/benes_cfg_loader.sv
// Assembles per-stage switch words into a shadow bank and commits them atomically to the active bank.
// Optional even-parity checking of each word is enabled by defining BENES_CFG_PARITY_EN.
module benes_cfg_loader #(
  parameter  int N_PORTS      = 32,
  localparam int LOG2N        = $clog2(N_PORTS),
  localparam int NUM_STAGES   = 2*LOG2N-1,
  localparam int SW_PER_STAGE = N_PORTS/2
) (
  input  logic                               clk,
  input  logic                               rst,
  benes_cfg_if.slave                         cfg,
  input  logic                               net_idle,
  output logic [NUM_STAGES*SW_PER_STAGE-1:0] switch_set,
  output logic                               cfg_done,
  output logic                               cfg_err
);
  localparam int CNT_W = $clog2(NUM_STAGES+1);
  localparam int BANK_W = NUM_STAGES*SW_PER_STAGE;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, COMMIT} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BANK_W-1:0]  shadow_q, shadow_d;
  logic [BANK_W-1:0]  active_q, active_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               ready_q, ready_d;
  logic               xfer, par_bad, last_idx;

  assign xfer     = cfg.cfg_valid & ready_q;
  assign last_idx = (cnt_q == CNT_W'(NUM_STAGES-1));
`ifdef BENES_CFG_PARITY_EN
  assign par_bad  = ^{cfg.cfg_data, cfg.cfg_parity};
`else
  assign par_bad  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    err_d    = err_q;
    // Word lands in the slot named by the counter (0 in IDLE)
    if (xfer && (state_q == IDLE || state_q == LOAD)) begin
      for (int s = 0; s < NUM_STAGES; s++)
        if (cnt_q == CNT_W'(s)) shadow_d[s*SW_PER_STAGE +: SW_PER_STAGE] = cfg.cfg_data;
    end
    case (state_q)
      IDLE: if (xfer) begin
        err_d = 1'b0;
        cnt_d = CNT_W'(1);
        state_d = LOAD;
        if (par_bad) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = cfg.cfg_last ? IDLE : DRAIN;
        end else if (cfg.cfg_last) begin
          err_d    = 1'b1;
          cnt_d    = '0;
          shadow_d = '0;
          state_d  = IDLE;
        end
      end
      LOAD: if (xfer) begin
        cnt_d = cnt_q + CNT_W'(1);
        if (par_bad) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = cfg.cfg_last ? IDLE : DRAIN;
        end else if (last_idx) begin
          if (cfg.cfg_last) state_d = COMMIT;
          else begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = DRAIN;
          end
        end else if (cfg.cfg_last) begin
          err_d    = 1'b1;
          cnt_d    = '0;
          shadow_d = '0;
          state_d  = IDLE;
        end
      end
      DRAIN: if (xfer && cfg.cfg_last) state_d = IDLE;
      COMMIT: if (net_idle) begin
        active_d = shadow_q;
        cnt_d    = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready is decoded from the next state so it is a clean register output
  always_comb begin
    ready_d = (state_d != COMMIT);
    done_d  = (state_q == COMMIT) && net_idle;
  end

  assign cfg.cfg_ready = ready_q;
  assign switch_set    = active_q;
  assign cfg_done      = done_q;
  assign cfg_err       = err_q;
endmodule

// File: tb/tb_benes_cfg_loader.sv
// Scoreboard bench for benes_cfg_loader: committed banks are queued at frame send, popped on cfg_done.
module tb_benes_cfg_loader;
  localparam int NP = 32;
  localparam int SW = 16;
  localparam int NS = 9;
  localparam int W  = NS*SW;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         net_idle = 1'b1;
  logic [W-1:0] switch_set;
  logic         cfg_done;
  logic         cfg_err;

  always #5 clk = ~clk;

  benes_cfg_if #(.SW_PER_STAGE(SW)) ifc ();

  benes_cfg_loader #(.N_PORTS(NP)) dut (
    .clk(clk), .rst(rst), .cfg(ifc), .net_idle(net_idle),
    .switch_set(switch_set), .cfg_done(cfg_done), .cfg_err(cfg_err)
  );

  int           n_chk = 0;
  int           n_err = 0;
  logic [W-1:0] sbq[$];
  logic [W-1:0] exp_act;
  logic [W-1:0] pat;
  logic [SW-1:0] fr [NS];
  logic         bad;

  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] flat();
    logic [W-1:0] v;
    for (int s = 0; s < NS; s++) v[s*SW +: SW] = fr[s];
    return v;
  endfunction

  task automatic randomize_frame();
    for (int s = 0; s < NS; s++) fr[s] = SW'($urandom);
  endtask

  // Called at a negedge; returns at the negedge after the word transfers
  task automatic send_word(input logic [SW-1:0] d, input logic last, input logic flip);
    int n;
    ifc.cfg_valid = 1'b1;
    ifc.cfg_data  = d;
    ifc.cfg_last  = last;
`ifdef BENES_CFG_PARITY_EN
    ifc.cfg_parity = (^d) ^ flip;
`else
    if (flip) ifc.cfg_data = d;
`endif
    n = 0;
    while (!ifc.cfg_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("ready_timeout", W'(0), W'(1));
    @(posedge clk);
    @(negedge clk);
    ifc.cfg_valid = 1'b0;
    ifc.cfg_last  = 1'b0;
  endtask

  task automatic send_frame(input int nwords, input int flip_idx);
    for (int i = 0; i < nwords; i++)
      send_word(fr[i % NS], (i == nwords-1), (i == flip_idx));
  endtask

  always @(negedge clk) begin
    if (!rst && cfg_done) begin
      if (sbq.size() == 0) check("unexpected_done", W'(1), W'(0));
      else check("commit_bank", switch_set, sbq.pop_front());
    end
  end

  initial begin
    ifc.cfg_valid = 1'b0;
    ifc.cfg_data  = '0;
    ifc.cfg_last  = 1'b0;
`ifdef BENES_CFG_PARITY_EN
    ifc.cfg_parity = 1'b0;
`endif
    exp_act = '0;

    // reset
    @(negedge clk);
    check("rst_ready", W'(ifc.cfg_ready), W'(0));
    @(negedge clk);
    check("rst_ready2", W'(ifc.cfg_ready), W'(0));
    check("rst_switch", switch_set, '0);
    check("rst_done", W'(cfg_done), W'(0));
    check("rst_err", W'(cfg_err), W'(0));
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", W'(ifc.cfg_ready), W'(1));

    // diagonal frame, immediate commit
    for (int s = 0; s < NS; s++) fr[s] = SW'(1) << s;
    pat = '0;
    for (int s = 0; s < NS; s++) pat[s*SW + s] = 1'b1;
    exp_act = pat;
    sbq.push_back(exp_act);
    send_frame(NS, -1);
    check("ready_in_commit", W'(ifc.cfg_ready), W'(0));
    check("no_early_done", W'(cfg_done), W'(0));
    @(negedge clk);
    check("done_latency", W'(cfg_done), W'(1));
    check("diag_pattern", switch_set, pat);
    @(negedge clk);
    check("done_pulse", W'(cfg_done), W'(0));

    // commit held off by busy network
    net_idle = 1'b0;
    randomize_frame();
    send_frame(NS, -1);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ifc.cfg_ready || cfg_done || switch_set !== exp_act) bad = 1'b1;
      @(negedge clk);
    end
    check("hold_while_busy", W'(bad), W'(0));
    exp_act = flat();
    sbq.push_back(exp_act);
    net_idle = 1'b1;
    @(negedge clk);
    check("commit_after_idle", W'(cfg_done), W'(1));

    // short frame: cfg_last on word index 4
    randomize_frame();
    send_frame(5, -1);
    check("short_err", W'(cfg_err), W'(1));
    repeat (3) @(negedge clk);
    check("short_no_commit", switch_set, exp_act);
    check("short_ready", W'(ifc.cfg_ready), W'(1));
    randomize_frame();
    exp_act = flat();
    sbq.push_back(exp_act);
    for (int i = 0; i < NS; i++) begin
      send_word(fr[i], (i == NS-1), 1'b0);
      if (i == 0) check("err_cleared", W'(cfg_err), W'(0));
    end
    @(negedge clk);
    check("recover_commit", switch_set, exp_act);

    // long frame: 11 words
    randomize_frame();
    for (int i = 0; i < 11; i++) begin
      send_word(fr[i % NS], (i == 10), 1'b0);
      if (i == NS-2) check("long_err_early", W'(cfg_err), W'(0));
      if (i == NS-1) check("long_err_at_9", W'(cfg_err), W'(1));
    end
    repeat (3) @(negedge clk);
    check("long_no_commit", switch_set, exp_act);
    check("long_err_sticky", W'(cfg_err), W'(1));
    randomize_frame();
    exp_act = flat();
    sbq.push_back(exp_act);
    send_frame(NS, -1);
    @(negedge clk);
    check("long_then_commit", switch_set, exp_act);

    // mid-frame reset
    randomize_frame();
    send_frame(5, -1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_act = '0;
    check("midrst_switch", switch_set, '0);
    check("midrst_done", W'(cfg_done), W'(0));
    @(negedge clk);
    randomize_frame();
    exp_act = flat();
    sbq.push_back(exp_act);
    send_frame(NS, -1);
    @(negedge clk);
    check("midrst_commit", switch_set, exp_act);

`ifdef BENES_CFG_PARITY_EN
    randomize_frame();
    send_frame(NS, 3);
    check("parity_err", W'(cfg_err), W'(1));
    repeat (3) @(negedge clk);
    check("parity_no_commit", switch_set, exp_act);
`endif

    repeat (3) @(negedge clk);
    check("sb_empty", W'(sbq.size()), W'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
